// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry, scan state type and row extraction for the matrix driver
package matrix_pkg;
  localparam int MATRIX_ROWS = 7;
  localparam int MATRIX_COLS = 5;
  localparam int IMG_W = MATRIX_ROWS * MATRIX_COLS;
  localparam int ROW_W = $clog2(MATRIX_ROWS);
  typedef enum logic {BLANK, SHOW} scan_state_t;
  function automatic logic [MATRIX_COLS-1:0] row_bits(input logic [IMG_W-1:0] img, input logic [ROW_W-1:0] r);
    return img[r * MATRIX_COLS +: MATRIX_COLS];
  endfunction
endpackage

// File: rtl/matrix_scan_driver_if.sv
// matrix_scan_driver_if: image write handshake into the matrix scan driver
interface matrix_scan_driver_if;
  import matrix_pkg::*;
  logic wr_valid;
  logic wr_sel;
  logic [IMG_W-1:0] wr_data;
  logic wr_ready;
  modport master(output wr_valid, wr_sel, wr_data, input wr_ready);
  modport slave(input wr_valid, wr_sel, wr_data, output wr_ready);
endinterface

// File: rtl/scan_timer.sv
// scan_timer: slot, row and frame counters pacing the matrix scan
module scan_timer
  import matrix_pkg::*;
#(
  parameter int ROW_TICKS = 65536,
  parameter int FRAMES_PER_IMAGE = 36,
  parameter int CW = $clog2(ROW_TICKS + 1)
) (
  input  logic clk,
  input  logic rst,
  output logic [CW-1:0] count,
  output logic [ROW_W-1:0] row,
  output logic slot_wrap,
  output logic row_wrap,
  output logic frame_done
);
  localparam int FW = $clog2(FRAMES_PER_IMAGE + 1);
  logic [FW-1:0] frames;
  always_comb begin
    slot_wrap = count == CW'(ROW_TICKS - 1);
    row_wrap = slot_wrap && row == ROW_W'(MATRIX_ROWS - 1);
    frame_done = row_wrap && frames == FW'(FRAMES_PER_IMAGE - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      row <= '0;
      frames <= '0;
    end else begin
      count <= slot_wrap ? '0 : count + 1'b1;
      if (slot_wrap) row <= row_wrap ? '0 : row + 1'b1;
      if (row_wrap) frames <= frame_done ? '0 : frames + 1'b1;
    end
endmodule

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: row-multiplexed 7x5 matrix driver with two frame-synchronous image buffers
// MATRIX_BLANK_EN adds a blanking interval of BLANK_TICKS at the start of every row slot
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int ROW_TICKS = 65536,
  parameter int BLANK_TICKS = 256,
  parameter int FRAMES_PER_IMAGE = 36
) (
  input  logic clk,
  input  logic rst,
  matrix_scan_driver_if.slave wr,
  output logic [MATRIX_ROWS-1:0] linhas,
  output logic [MATRIX_COLS-1:0] colunas,
  output logic [ROW_W-1:0] Seletor_Linhas,
  output logic Seletor_imagem,
  output logic frame_start
);
  localparam int CW = $clog2(ROW_TICKS + 1);
`ifdef MATRIX_BLANK_EN
  localparam int BT = BLANK_TICKS;
  localparam scan_state_t SLOT_START = BLANK;
`else
  localparam int BT = 0;
  localparam scan_state_t SLOT_START = SHOW;
`endif
  if (BLANK_TICKS >= ROW_TICKS) begin : g_blank_check
    $error("BLANK_TICKS must be less than ROW_TICKS");
  end
  logic [CW-1:0] count;
  logic [ROW_W-1:0] row;
  logic slot_wrap, row_wrap, frame_done;
  scan_state_t state_q, state_d;
  logic pending, pending_d, accept, commit, wrapped, sh_sel;
  logic [IMG_W-1:0] sh_data;
  logic [IMG_W-1:0] img [2];
  logic [MATRIX_ROWS-1:0] linhas_d;
  logic [MATRIX_COLS-1:0] colunas_d;
  scan_timer #(
    .ROW_TICKS(ROW_TICKS),
    .FRAMES_PER_IMAGE(FRAMES_PER_IMAGE),
    .CW(CW)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .count(count),
    .row(row),
    .slot_wrap(slot_wrap),
    .row_wrap(row_wrap),
    .frame_done(frame_done)
  );
  // with BT=0 the SHOW match value lies above any slot count, so the slot stays in SHOW
  always_comb begin
    state_d = slot_wrap ? SLOT_START : count == CW'(BT - 1) ? SHOW : state_q;
    accept = wr.wr_valid && wr.wr_ready;
    commit = pending && row_wrap;
    pending_d = accept || (pending && !row_wrap);
    linhas_d = state_q == SHOW ? ~(MATRIX_ROWS'(1) << row) : '1;
    colunas_d = state_q == SHOW ? row_bits(img[Seletor_imagem], row) : '0;
  end
  // a write accepted on the wrap edge has pending low there, so it waits a full frame
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= SLOT_START;
      pending <= 1'b0;
      wr.wr_ready <= 1'b0;
      sh_sel <= 1'b0;
      sh_data <= '0;
      img[0] <= '0;
      img[1] <= '0;
      wrapped <= 1'b0;
      linhas <= '1;
      colunas <= '0;
      Seletor_Linhas <= '0;
      Seletor_imagem <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      wr.wr_ready <= !pending_d;
      if (accept) {sh_sel, sh_data} <= {wr.wr_sel, wr.wr_data};
      if (commit) img[sh_sel] <= sh_data;
      if (frame_done) Seletor_imagem <= !Seletor_imagem;
      wrapped <= row_wrap;
      frame_start <= wrapped;
      Seletor_Linhas <= row;
      linhas <= linhas_d;
      colunas <= colunas_d;
    end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver: directed scan, write, image toggle, wrap collision and reset checks
module tb_matrix_scan_driver;
`ifdef MATRIX_BLANK_EN
  localparam int BL = 4;
`else
  localparam int BL = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic [2:0] sel_l;
  logic sel_i, fs;
  int errors = 0;
  int checks = 0;
  int t = -1;
  logic [34:0] e_img [2];
  logic e_rdy;
  matrix_scan_driver_if wr_if();
  matrix_scan_driver #(
    .ROW_TICKS(16),
    .BLANK_TICKS(4),
    .FRAMES_PER_IMAGE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr(wr_if),
    .linhas(linhas),
    .colunas(colunas),
    .Seletor_Linhas(sel_l),
    .Seletor_imagem(sel_i),
    .frame_start(fs)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask
  task automatic reset_checks();
    chk("rst_linhas", linhas, 7'h7F);
    chk("rst_colunas", colunas, 5'd0);
    chk("rst_sel_linhas", sel_l, 3'd0);
    chk("rst_frame_start", fs, 1'b0);
    chk("rst_wr_ready", wr_if.wr_ready, 1'b0);
    chk("rst_sel_imagem", sel_i, 1'b0);
  endtask
  task automatic check_cycle();
    int r;
    bit show;
    logic [6:0] one;
    logic [6:0] e_lin;
    logic [4:0] e_col;
    logic [34:0] im;
    r = (t / 16) % 7;
    show = (t % 16) >= BL;
    one = 7'd1;
    im = e_img[(t / 224) % 2];
    e_lin = show ? ~(one << r) : 7'h7F;
    e_col = show ? im[r * 5 +: 5] : 5'd0;
    chk("linhas", linhas, e_lin);
    chk("colunas", colunas, e_col);
    chk("sel_linhas", sel_l, r[2:0]);
    chk("frame_start", fs, (t > 0 && t % 112 == 0) ? 1'b1 : 1'b0);
    chk("sel_imagem", sel_i, ((t + 1) / 224) % 2 == 1 ? 1'b1 : 1'b0);
    chk("wr_ready", wr_if.wr_ready, e_rdy);
  endtask
  task automatic run_to(input int n);
    while (t < n) begin
      @(negedge clk);
      t++;
      check_cycle();
    end
  endtask
  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_sel = 1'b0;
    wr_if.wr_data = '0;
    e_img[0] = '0;
    e_img[1] = '0;
    e_rdy = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    // frame 0: write row0=10101 to image 0, then hold garbage on the bus while pending
    run_to(30);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_sel = 1'b0;
    wr_if.wr_data = 35'h15;
    e_rdy = 1'b0;
    run_to(31);
    wr_if.wr_sel = 1'b1;
    wr_if.wr_data = '1;
    run_to(100);
    wr_if.wr_valid = 1'b0;
    run_to(110);
    e_rdy = 1'b1;
    e_img[0] = 35'h15;
    run_to(111);
    // frame 1: image 1 row3=11111, shown after the toggle at 224
    run_to(150);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_sel = 1'b1;
    wr_if.wr_data = 35'h0F8000;
    e_rdy = 1'b0;
    run_to(151);
    wr_if.wr_valid = 1'b0;
    run_to(222);
    e_rdy = 1'b1;
    e_img[1] = 35'h0F8000;
    run_to(223);
    // write accepted on the wrap edge at the end of tick 447 lands one frame later
    run_to(446);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_sel = 1'b0;
    wr_if.wr_data = 35'h3800;
    e_rdy = 1'b0;
    run_to(447);
    wr_if.wr_valid = 1'b0;
    run_to(558);
    e_rdy = 1'b1;
    e_img[0] = 35'h3800;
    run_to(559);
    // reset in row 4 with a write pending
    run_to(620);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_sel = 1'b1;
    wr_if.wr_data = '1;
    e_rdy = 1'b0;
    run_to(621);
    wr_if.wr_valid = 1'b0;
    run_to(629);
    rst = 1'b1;
    @(negedge clk);
    reset_checks();
    rst = 1'b0;
    t = -1;
    e_img[0] = '0;
    e_img[1] = '0;
    e_rdy = 1'b1;
    run_to(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
